// File: rtl/cache_miss_ctrl_pkg.sv
// Shared definitions for the two-way cache miss controller: geometry,
// FSM state encodings and way-selection helpers.
package cache_miss_ctrl_pkg;

  localparam int CACHE_INDEX_AW = 8;
  localparam int CACHE_DEPTH    = 1 << CACHE_INDEX_AW;

  localparam logic [2:0] ST_IDLE        = 3'd0;
  localparam logic [2:0] ST_LOOKUP      = 3'd1;
  localparam logic [2:0] ST_WB          = 3'd2;
  localparam logic [2:0] ST_REFILL      = 3'd3;
  localparam logic [2:0] ST_REFILL_WAIT = 3'd4;
  localparam logic [2:0] ST_UPDATE      = 3'd5;

  // Both ways hitting is resolved in favour of way 0.
  function automatic logic hit_way(input logic [1:0] hit);
    return hit[0] ? 1'b0 : 1'b1;
  endfunction

  function automatic logic victim_dirty(input logic [1:0] dirty, input logic way);
    return way ? dirty[1] : dirty[0];
  endfunction

endpackage

// File: rtl/cache_miss_ctrl_if.sv
// Request, LRU-table, writeback, refill, response and statistics signals
// of the cache miss controller.
interface cache_miss_ctrl_if
  import cache_miss_ctrl_pkg::*;
#(
  parameter int INDEX_AW = CACHE_INDEX_AW
);

  logic                req_valid_i;
  logic                req_ready_o;
  logic [INDEX_AW-1:0] req_index_i;
  logic [1:0]          hit_i;
  logic [1:0]          dirty_i;
  logic [INDEX_AW-1:0] lru_index_o;
  logic                lru_wr_en_o;
  logic                lru_wr_lru_o;
  logic                lru_rd_i;
  logic                wb_valid_o;
  logic                wb_ready_i;
  logic                wb_way_o;
  logic                refill_valid_o;
  logic                refill_ready_i;
  logic                refill_done_i;
  logic                resp_valid_o;
  logic                resp_hit_o;
  logic                resp_way_o;
  logic [15:0]         hit_cnt_o;
  logic [15:0]         miss_cnt_o;

  modport slave (
    input  req_valid_i, req_index_i, hit_i, dirty_i, lru_rd_i,
           wb_ready_i, refill_ready_i, refill_done_i,
    output req_ready_o, lru_index_o, lru_wr_en_o, lru_wr_lru_o,
           wb_valid_o, wb_way_o, refill_valid_o,
           resp_valid_o, resp_hit_o, resp_way_o, hit_cnt_o, miss_cnt_o
  );

  modport master (
    output req_valid_i, req_index_i, hit_i, dirty_i, lru_rd_i,
           wb_ready_i, refill_ready_i, refill_done_i,
    input  req_ready_o, lru_index_o, lru_wr_en_o, lru_wr_lru_o,
           wb_valid_o, wb_way_o, refill_valid_o,
           resp_valid_o, resp_hit_o, resp_way_o, hit_cnt_o, miss_cnt_o
  );

endinterface

// File: rtl/cache_miss_ctrl.sv
// Two-way cache miss controller: lookup, dirty-victim writeback, line refill
// and LRU update, with hit/miss statistics.
module cache_miss_ctrl
  import cache_miss_ctrl_pkg::*;
#(
  parameter int INDEX_AW = CACHE_INDEX_AW
) (
  input logic              clk,
  input logic              rst_n,
  cache_miss_ctrl_if.slave bus
);

  logic [2:0]          state_r;
  logic [2:0]          state_nxt_s;
  logic [INDEX_AW-1:0] index_r;
  logic                way_r;
  logic                hit_r;
  logic [15:0]         hit_cnt_r;
  logic [15:0]         miss_cnt_r;

  logic accept_s;
  logic lookup_hit_s;
  logic lookup_way_s;
  logic in_lookup_s;

  assign accept_s     = (state_r == ST_IDLE) && bus.req_valid_i;
  assign in_lookup_s  = (state_r == ST_LOOKUP);
  assign lookup_hit_s = (bus.hit_i != 2'b00);
  // On a miss the LRU bit read at acceptance names the victim way.
  assign lookup_way_s = lookup_hit_s ? hit_way(bus.hit_i) : bus.lru_rd_i;

  // Next-state selection for the miss-handling sequence.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (bus.req_valid_i) begin
          state_nxt_s = ST_LOOKUP;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_LOOKUP: begin
        if (lookup_hit_s) begin
          state_nxt_s = ST_UPDATE;
        end else if (victim_dirty(bus.dirty_i, lookup_way_s)) begin
          state_nxt_s = ST_WB;
        end else begin
          state_nxt_s = ST_REFILL;
        end
      end
      ST_WB: begin
        if (bus.wb_ready_i) begin
          state_nxt_s = ST_REFILL;
        end else begin
          state_nxt_s = ST_WB;
        end
      end
      ST_REFILL: begin
        if (bus.refill_ready_i) begin
          state_nxt_s = ST_REFILL_WAIT;
        end else begin
          state_nxt_s = ST_REFILL;
        end
      end
      ST_REFILL_WAIT: begin
        if (bus.refill_done_i) begin
          state_nxt_s = ST_UPDATE;
        end else begin
          state_nxt_s = ST_REFILL_WAIT;
        end
      end
      ST_UPDATE: state_nxt_s = ST_IDLE;
      default:   state_nxt_s = ST_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Captured set index and lookup outcome for the transaction in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      index_r <= {INDEX_AW{1'b0}};
      way_r   <= 1'b0;
      hit_r   <= 1'b0;
    end else begin
      if (accept_s) begin
        index_r <= bus.req_index_i;
      end
      if (in_lookup_s) begin
        way_r <= lookup_way_s;
        hit_r <= lookup_hit_s;
      end
    end
  end

  // Hit/miss statistics, free-running with natural 16-bit wrap.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hit_cnt_r  <= 16'h0000;
      miss_cnt_r <= 16'h0000;
    end else if (in_lookup_s) begin
      if (lookup_hit_s) begin
        hit_cnt_r <= hit_cnt_r + 16'd1;
      end else begin
        miss_cnt_r <= miss_cnt_r + 16'd1;
      end
    end
  end

  // Outputs decode directly from state registers so reset clears them at once.
  assign bus.req_ready_o    = (state_r == ST_IDLE);
  assign bus.lru_index_o    = (state_r == ST_IDLE) ? bus.req_index_i : index_r;
  assign bus.lru_wr_en_o    = (state_r == ST_UPDATE);
  assign bus.lru_wr_lru_o   = (state_r == ST_UPDATE) && !way_r;
  assign bus.wb_valid_o     = (state_r == ST_WB);
  assign bus.wb_way_o       = (state_r == ST_WB) && way_r;
  assign bus.refill_valid_o = (state_r == ST_REFILL);
  assign bus.resp_valid_o   = (state_r == ST_UPDATE);
  assign bus.resp_hit_o     = (state_r == ST_UPDATE) && hit_r;
  assign bus.resp_way_o     = (state_r == ST_UPDATE) && way_r;
  assign bus.hit_cnt_o      = hit_cnt_r;
  assign bus.miss_cnt_o     = miss_cnt_r;

endmodule

// File: doc/cache_miss_ctrl.md
CACHE_MISS_CTRL -- requirements
Module: cache_miss_ctrl

Interface
REQ-001 SHALL have parameter INDEX_AW, default `CACHE_INDEX_AW (8), meaning set-index width; it matches the LRU table address width.
REQ-002 SHALL have port clk  in  1  single clock; all state changes on rising edge.
REQ-003 SHALL have port rst_n  in  1  reset, asynchronous, active-low.
REQ-004 SHALL have ports req_valid_i  in  1 / req_ready_o  out  1 / req_index_i  in  INDEX_AW  lookup request handshake and set index.
REQ-005 SHALL have ports hit_i  in  2  per-way tag-hit / dirty_i  in  2  per-way dirty bits, both valid in the LOOKUP cycle.
REQ-006 SHALL have ports lru_index_o  out  INDEX_AW / lru_wr_en_o  out  1 / lru_wr_lru_o  out  1 / lru_rd_i  in  1  for the 1-bit-per-set LRU table (1-cycle synchronous read).
REQ-007 SHALL have ports wb_valid_o  out  1 / wb_ready_i  in  1 / wb_way_o  out  1  dirty-victim writeback handshake.
REQ-008 SHALL have ports refill_valid_o  out  1 / refill_ready_i  in  1 / refill_done_i  in  1  line refill handshake plus completion pulse.
REQ-009 SHALL have ports resp_valid_o  out  1 / resp_hit_o  out  1 / resp_way_o  out  1  completion response.
REQ-010 SHALL have ports hit_cnt_o  out  16 / miss_cnt_o  out  16  access statistics.

Function
REQ-011 SHALL implement states IDLE, LOOKUP, WB, REFILL, REFILL_WAIT, UPDATE.
REQ-012 SHALL drive req_ready_o=1 only in IDLE; on req_valid_i&req_ready_o it captures req_index_i and enters LOOKUP.
REQ-013 SHALL drive lru_index_o = req_index_i in IDLE and the captured index in all other states, so the LRU read issued at acceptance is returned in LOOKUP.
REQ-014 In LOOKUP, hit (hit_i!=0) SHALL select way = 0 if hit_i[0] else 1 (hit_i=2'b11 resolves to way 0), go to UPDATE, and increment hit_cnt_o.
REQ-015 In LOOKUP, miss SHALL select victim way = lru_rd_i, increment miss_cnt_o, and go to WB if dirty_i[victim], else REFILL.
REQ-016 WB SHALL hold wb_valid_o=1 and wb_way_o=victim until wb_ready_i is sampled high, then go to REFILL.
REQ-017 REFILL SHALL hold refill_valid_o=1 until refill_ready_i is sampled high, then go to REFILL_WAIT; refill_done_i outside REFILL_WAIT SHALL be ignored.
REQ-018 REFILL_WAIT SHALL go to UPDATE on refill_done_i=1.
REQ-019 UPDATE SHALL last exactly one cycle, assert lru_wr_en_o=1 with lru_wr_lru_o = ~way (LRU bit names the next victim), assert resp_valid_o=1 with resp_way_o=way and resp_hit_o = hit outcome, then return to IDLE.
REQ-020 Hit latency SHALL be 2 cycles from acceptance edge to resp_valid_o; a clean miss with ready/done each returned one cycle after request SHALL respond 4 cycles after acceptance.
REQ-021 lru_wr_en_o, wb_valid_o, refill_valid_o, resp_valid_o SHALL be 0 in all states not listed for them.
REQ-022 Counters SHALL wrap from 16'hFFFF to 0.

Reset
REQ-023 rst_n low SHALL immediately force IDLE, zero the captured index, way, hit flag and both counters, from any state including mid-handshake.
REQ-024 During and after reset all outputs SHALL be 0 except req_ready_o=1.

Structure
REQ-025 State encodings and CACHE_INDEX_AW/CACHE_DEPTH SHALL live in the shared defines file.
REQ-026 No sub-module SHALL be used; the LRU table is instantiated alongside by the parent cache.

Verification
REQ-027 Reset, idle index 8'h12, hit_i=2'b10 -> resp at +2 cycles, resp_hit_o=1, resp_way_o=1, lru write index 8'h12 value 0, hit_cnt_o=1.
REQ-028 Miss, lru_rd_i=0, dirty_i=2'b00, refill ready/done immediate -> no wb_valid_o, resp at +4, resp_way_o=0, lru_wr_lru_o=1, miss_cnt_o=1.
REQ-029 Miss, lru_rd_i=1, dirty_i=2'b10, wb_ready_i delayed 3 cycles -> wb_valid_o held 3 cycles with wb_way_o=1, then refill, resp_way_o=1.
REQ-030 refill_done_i pulsed during REFILL before refill_ready_i -> ignored; resp only after done in REFILL_WAIT.
REQ-031 rst_n low during WB -> outputs cleared same cycle, counters 0, next request served normally.
REQ-032 hit_cnt_o preset by 65535 hits, one more hit -> hit_cnt_o=0.
